// File: rtl/serdes_tx_pkg.sv
// Shared types and constants for the TX serializer: FSM states, training/idle words, PRBS7 setup.
package serdes_tx_pkg;

    typedef enum logic {
        TRAIN,
        RUN
    } tx_state_e;

    localparam logic [9:0] TRAIN_WORD = 10'b1010101010;
    // K28.5 RD-, bit a at bit0
    localparam logic [9:0] IDLE_WORD  = 10'b0101111100;

    localparam logic [6:0]  PRBS7_SEED  = 7'h7F;
    localparam int unsigned PRBS7_TAP_A = 6;  // x^7
    localparam int unsigned PRBS7_TAP_B = 5;  // x^6

endpackage

// File: rtl/tx_serializer_if.sv
// Parallel word handshake into the TX serializer.
interface tx_serializer_if #(
    parameter int unsigned WIDTH = 10
);
    logic [WIDTH-1:0] Din;
    logic             Din_valid;
    logic             Din_ready;

    modport master (output Din, output Din_valid, input Din_ready);
    modport slave  (input Din, input Din_valid, output Din_ready);
endinterface

// File: rtl/prbs7_gen.sv
// PRBS7 (x^7+x^6+1) bit source; advances one step per cycle while en is high.
// Only present when PRBS_GEN_EN is defined.
`ifdef PRBS_GEN_EN
module prbs7_gen
    import serdes_tx_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic bit_out
);
    logic [6:0] lfsr;

    assign bit_out = lfsr[PRBS7_TAP_A] ^ lfsr[PRBS7_TAP_B];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr <= PRBS7_SEED;
        end else if (en) begin
            lfsr <= {lfsr[5:0], bit_out};
        end
    end
endmodule
`endif

// File: rtl/tx_serializer.sv
// LSB-first word serializer with training bursts, K28.5 idle fill and a sticky run-length monitor.
// Define PRBS_GEN_EN to add the prbs_mode port and a PRBS7 payload source.
module tx_serializer
    import serdes_tx_pkg::*;
#(
    parameter int unsigned WIDTH       = 10,
    parameter int unsigned TRAIN_WORDS = 16,
    parameter int unsigned MAX_RUN     = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    tx_serializer_if.slave word_bus,
    input  logic           train_req,
`ifdef PRBS_GEN_EN
    input  logic           prbs_mode,
`endif
    output logic           Dout,
    output logic           word_strobe,
    output logic           train_active,
    output logic           run_len_err
);
    localparam int unsigned CNT_W  = $clog2(WIDTH);
    localparam int unsigned TCNT_W = $clog2(TRAIN_WORDS + 1);
    localparam int unsigned RUN_W  = $clog2(MAX_RUN + 2);
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WIDTH - 1);
    localparam logic [TCNT_W-1:0] TRAIN_END = TCNT_W'(TRAIN_WORDS);
    localparam logic [RUN_W-1:0]  RUN_TRIP  = RUN_W'(MAX_RUN + 1);

    tx_state_e         state, state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [TCNT_W-1:0] train_cnt, train_cnt_nxt;
    logic              train_pending, pending_nxt;
    logic [WIDTH-1:0]  shift_reg, shift_nxt;
    logic              train_active_nxt;
    logic [RUN_W-1:0]  run_cnt, run_nxt;
    logic              boundary;
    logic              din_ready;

`ifdef PRBS_GEN_EN
    logic prbs_bit, prbs_slot, prbs_slot_nxt;

    prbs7_gen u_prbs (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (prbs_slot_nxt),
        .bit_out (prbs_bit)
    );
`endif

    always_comb begin
        boundary         = (bit_cnt == LAST_BIT);
        state_nxt        = state;
        train_cnt_nxt    = train_cnt;
        pending_nxt      = train_pending;
        train_active_nxt = train_active;
        shift_nxt        = {1'b0, shift_reg[WIDTH-1:1]};
        din_ready        = 1'b0;
`ifdef PRBS_GEN_EN
        prbs_slot_nxt    = prbs_slot;
`endif
        if (boundary) begin
            unique case (state)
                TRAIN: begin
                    if (train_cnt == TRAIN_END) begin
                        state_nxt        = RUN;
                        train_active_nxt = 1'b0;
                        shift_nxt        = IDLE_WORD;
`ifdef PRBS_GEN_EN
                        prbs_slot_nxt    = prbs_mode;
`endif
                    end else begin
                        train_cnt_nxt    = train_cnt + TCNT_W'(1);
                        train_active_nxt = 1'b1;
                        shift_nxt        = TRAIN_WORD;
                    end
                end
                RUN: begin
                    if (train_req || train_pending) begin
                        state_nxt        = TRAIN;
                        train_cnt_nxt    = TCNT_W'(1);
                        pending_nxt      = 1'b0;
                        train_active_nxt = 1'b1;
                        shift_nxt        = TRAIN_WORD;
`ifdef PRBS_GEN_EN
                        prbs_slot_nxt    = 1'b0;
`endif
                    end else begin
                        train_active_nxt = 1'b0;
`ifdef PRBS_GEN_EN
                        prbs_slot_nxt    = prbs_mode;
                        din_ready        = !prbs_mode;
`else
                        din_ready        = 1'b1;
`endif
                        shift_nxt = (din_ready && word_bus.Din_valid) ? word_bus.Din : IDLE_WORD;
                    end
                end
                default: ;
            endcase
        end else if (state == RUN && train_req) begin
            pending_nxt = 1'b1;
        end
`ifdef PRBS_GEN_EN
        // PRBS slots keep the word framing; only the outgoing bit is replaced
        if (prbs_slot_nxt) begin
            shift_nxt[0] = prbs_bit;
        end
`endif
        if (shift_nxt[0] == shift_reg[0]) begin
            run_nxt = (run_cnt == RUN_TRIP) ? run_cnt : run_cnt + RUN_W'(1);
        end else begin
            run_nxt = RUN_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= TRAIN;
            bit_cnt       <= LAST_BIT;
            train_cnt     <= '0;
            train_pending <= 1'b0;
            shift_reg     <= '0;
            word_strobe   <= 1'b0;
            train_active  <= 1'b0;
            run_cnt       <= RUN_W'(1);
            run_len_err   <= 1'b0;
`ifdef PRBS_GEN_EN
            prbs_slot     <= 1'b0;
`endif
        end else begin
            state         <= state_nxt;
            bit_cnt       <= boundary ? '0 : bit_cnt + CNT_W'(1);
            train_cnt     <= train_cnt_nxt;
            train_pending <= pending_nxt;
            shift_reg     <= shift_nxt;
            word_strobe   <= boundary;
            train_active  <= train_active_nxt;
            run_cnt       <= run_nxt;
            run_len_err   <= run_len_err || (run_nxt == RUN_TRIP);
`ifdef PRBS_GEN_EN
            prbs_slot     <= prbs_slot_nxt;
`endif
        end
    end

    assign Dout               = shift_reg[0];
    assign word_bus.Din_ready = din_ready;

endmodule

// File: tb/tb_tx_serializer.sv
// Self-checking bench for tx_serializer against a word-slot level reference model.
module tb_tx_serializer;
    localparam int unsigned WIDTH       = 10;
    localparam int unsigned TRAIN_WORDS = 16;
    localparam int unsigned MAX_RUN     = 5;
    localparam logic [WIDTH-1:0] TW = 10'b1010101010;
    localparam logic [WIDTH-1:0] IW = 10'b0101111100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic train_req = 1'b0;
    logic Dout, word_strobe, train_active, run_len_err;
`ifdef PRBS_GEN_EN
    logic prbs_mode = 1'b0;
`endif

    tx_serializer_if #(.WIDTH(WIDTH)) word_bus ();

    tx_serializer #(
        .WIDTH       (WIDTH),
        .TRAIN_WORDS (TRAIN_WORDS),
        .MAX_RUN     (MAX_RUN)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .word_bus     (word_bus),
        .train_req    (train_req),
`ifdef PRBS_GEN_EN
        .prbs_mode    (prbs_mode),
`endif
        .Dout         (Dout),
        .word_strobe  (word_strobe),
        .train_active (train_active),
        .run_len_err  (run_len_err)
    );

    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    // Reference model: queue of bits still to be sent after the current one.
    bit          exp_q[$];
    logic        exp_dout, exp_ws, exp_ta, exp_err, exp_ready;
    logic        obs_ready, accepted;
    int unsigned exp_run, m_left;
    bit          m_train, m_pending;

    task automatic reset_model();
        exp_q.delete();
        exp_dout  = 1'b0;
        exp_ws    = 1'b0;
        exp_ta    = 1'b0;
        exp_err   = 1'b0;
        exp_ready = 1'b0;
        exp_run   = 1;
        m_train   = 1'b1;
        m_left    = TRAIN_WORDS;
        m_pending = 1'b0;
    endtask

    // Advance one bit period: called at a negedge, returns at the next negedge.
    task automatic tick();
        bit bnd;
        bit nb;
        logic [WIDTH-1:0] w;
        #1;
        bnd       = (exp_q.size() == 0);
        exp_ready = bnd && !m_train && !train_req && !m_pending;
        obs_ready = word_bus.Din_ready;
        accepted  = obs_ready && word_bus.Din_valid;
        if (bnd) begin
            if (m_train && m_left > 0) begin
                w = TW; m_left--; exp_ta = 1'b1;
            end else if (m_train) begin
                w = IW; m_train = 1'b0; exp_ta = 1'b0;
            end else if (train_req || m_pending) begin
                w = TW; m_left = TRAIN_WORDS - 1; m_train = 1'b1; m_pending = 1'b0; exp_ta = 1'b1;
            end else begin
                w = word_bus.Din_valid ? word_bus.Din : IW; exp_ta = 1'b0;
            end
            for (int i = 0; i < WIDTH; i++) exp_q.push_back(w[i]);
        end else if (train_req && !m_train) begin
            m_pending = 1'b1;
        end
        @(posedge clk);
        nb = exp_q.pop_front();
        if (nb == exp_dout) begin
            if (exp_run <= MAX_RUN) exp_run++;
        end else begin
            exp_run = 1;
        end
        if (exp_run > MAX_RUN) exp_err = 1'b1;
        exp_dout = nb;
        exp_ws   = bnd;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        train_req = 1'b0;
        word_bus.Din = '0;
        word_bus.Din_valid = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({Dout, word_strobe, train_active, run_len_err, word_bus.Din_ready} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset: got {dout,ws,ta,err,rdy}=%b want 00000",
                     {Dout, word_strobe, train_active, run_len_err, word_bus.Din_ready});
        end
        reset_model();
        rst_n = 1'b1;
    endtask

    task automatic test_training();
        int unsigned ta_cycles = 0;
        int unsigned pat_bad = 0;
        word_bus.Din_valid = 1'b0;
        for (int c = 0; c < 190; c++) begin
            tick();
            n_tests++;
            if ({Dout, word_strobe, train_active, run_len_err, obs_ready} !==
                {exp_dout, exp_ws, exp_ta, exp_err, exp_ready}) begin
                n_fail++;
                $display("FAIL training cyc %0d: got {dout,ws,ta,err,rdy}=%b want %b", c,
                         {Dout, word_strobe, train_active, run_len_err, obs_ready},
                         {exp_dout, exp_ws, exp_ta, exp_err, exp_ready});
            end
            if (train_active === 1'b1) ta_cycles++;
            if (c < 160 && Dout !== 1'(c % 2)) pat_bad++;
            if (c >= 160 && Dout !== IW[(c - 160) % 10]) pat_bad++;
        end
        n_tests++;
        if (ta_cycles != 160) begin
            n_fail++;
            $display("FAIL train_len: got %0d train_active cycles want 160", ta_cycles);
        end
        n_tests++;
        if (pat_bad != 0) begin
            n_fail++;
            $display("FAIL train_idle_pattern: got %0d wrong bits want 0", pat_bad);
        end
    endtask

    task automatic test_single_word();
        logic [0:9] want_seq;
        bit got_acc = 1'b0;
        want_seq = 10'b1000001111;
        word_bus.Din = 10'h3C1;
        word_bus.Din_valid = 1'b1;
        for (int c = 0; c < 30 && !got_acc; c++) begin
            tick();
            n_tests++;
            if ({Dout, word_strobe, train_active, run_len_err, obs_ready} !==
                {exp_dout, exp_ws, exp_ta, exp_err, exp_ready}) begin
                n_fail++;
                $display("FAIL single_wait cyc %0d: got {dout,ws,ta,err,rdy}=%b want %b", c,
                         {Dout, word_strobe, train_active, run_len_err, obs_ready},
                         {exp_dout, exp_ws, exp_ta, exp_err, exp_ready});
            end
            got_acc = accepted;
        end
        word_bus.Din_valid = 1'b0;
        n_tests++;
        if (!got_acc) begin
            n_fail++;
            $display("FAIL single_accept: got no accept in 30 cycles want accept");
        end
        n_tests++;
        if (word_strobe !== 1'b1) begin
            n_fail++;
            $display("FAIL single_strobe: got word_strobe=%b want 1 on bit0", word_strobe);
        end
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            n_tests++;
            if (Dout !== want_seq[i]) begin
                n_fail++;
                $display("FAIL single_bit %0d: got %b want %b", i, Dout, want_seq[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] words [3];
        logic [29:0] want, got;
        int unsigned nacc = 0, ngot = 0, gaps_bad = 0, last = 0;
        for (int i = 0; i < 3; i++) words[i] = WIDTH'($urandom);
        want = {words[2], words[1], words[0]};
        got  = '0;
        word_bus.Din = words[0];
        word_bus.Din_valid = 1'b1;
        for (int c = 0; c < 80 && ngot < 30; c++) begin
            tick();
            n_tests++;
            if ({Dout, word_strobe, train_active, run_len_err, obs_ready} !==
                {exp_dout, exp_ws, exp_ta, exp_err, exp_ready}) begin
                n_fail++;
                $display("FAIL b2b cyc %0d: got {dout,ws,ta,err,rdy}=%b want %b", c,
                         {Dout, word_strobe, train_active, run_len_err, obs_ready},
                         {exp_dout, exp_ws, exp_ta, exp_err, exp_ready});
            end
            if (accepted) begin
                if (nacc > 0 && c - last != 10) gaps_bad++;
                last = c;
                nacc++;
                if (nacc < 3) word_bus.Din = words[nacc];
                else word_bus.Din_valid = 1'b0;
            end
            if (nacc > 0 && ngot < 30) begin
                got[ngot] = Dout;
                ngot++;
            end
        end
        word_bus.Din_valid = 1'b0;
        n_tests++;
        if (nacc != 3 || gaps_bad != 0) begin
            n_fail++;
            $display("FAIL b2b_ready: got %0d accepts, %0d bad gaps want 3 accepts, 0 bad gaps", nacc, gaps_bad);
        end
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL b2b_stream: got %h want %h", got, want);
        end
    endtask

    task automatic test_train_req();
        int unsigned ta_cycles = 0;
        bit got_acc = 1'b0;
        bit found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            tick();
            found = (exp_q.size() == 5) && !m_train;
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL treq_align: got no bit4 slot in 30 cycles want one");
        end
        word_bus.Din = WIDTH'($urandom);
        word_bus.Din_valid = 1'b1;
        train_req = 1'b1;
        for (int c = 0; c < 250 && !got_acc; c++) begin
            tick();
            train_req = 1'b0;
            n_tests++;
            if ({Dout, word_strobe, train_active, run_len_err, obs_ready} !==
                {exp_dout, exp_ws, exp_ta, exp_err, exp_ready}) begin
                n_fail++;
                $display("FAIL treq cyc %0d: got {dout,ws,ta,err,rdy}=%b want %b", c,
                         {Dout, word_strobe, train_active, run_len_err, obs_ready},
                         {exp_dout, exp_ws, exp_ta, exp_err, exp_ready});
            end
            if (train_active === 1'b1) ta_cycles++;
            got_acc = accepted;
        end
        word_bus.Din_valid = 1'b0;
        n_tests++;
        if (!got_acc || ta_cycles != 160) begin
            n_fail++;
            $display("FAIL treq_burst: got accept=%b train cycles=%0d want accept=1 train cycles=160", got_acc, ta_cycles);
        end
    endtask

    task automatic test_mid_reset();
        bit found = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            tick();
            found = (exp_q.size() == 3);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (!found || {Dout, word_strobe, train_active, run_len_err, word_bus.Din_ready} !== 5'b00000) begin
            n_fail++;
            $display("FAIL midreset: got found=%b {dout,ws,ta,err,rdy}=%b want found=1 00000", found,
                     {Dout, word_strobe, train_active, run_len_err, word_bus.Din_ready});
        end
        reset_model();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 175; c++) begin
            tick();
            n_tests++;
            if ({Dout, word_strobe, train_active, run_len_err, obs_ready} !==
                {exp_dout, exp_ws, exp_ta, exp_err, exp_ready}) begin
                n_fail++;
                $display("FAIL retrain cyc %0d: got {dout,ws,ta,err,rdy}=%b want %b", c,
                         {Dout, word_strobe, train_active, run_len_err, obs_ready},
                         {exp_dout, exp_ws, exp_ta, exp_err, exp_ready});
            end
            if (c == 0) begin
                n_tests++;
                if ({Dout, word_strobe, train_active} !== 3'b011) begin
                    n_fail++;
                    $display("FAIL retrain_first: got {dout,ws,ta}=%b want 011", {Dout, word_strobe, train_active});
                end
            end
        end
    endtask

    task automatic test_run_len();
        int unsigned nacc = 0, zr = 0, rise_zr = 0;
        bit seen = 1'b0;
        bit found = 1'b0;
        n_tests++;
        if (run_len_err !== 1'b0) begin
            n_fail++;
            $display("FAIL runlen_pre: got %b want 0", run_len_err);
        end
        for (int c = 0; c < 30 && !found; c++) begin
            tick();
            found = (exp_q.size() == 5) && !m_train;
        end
        word_bus.Din = '0;
        word_bus.Din_valid = 1'b1;
        for (int c = 0; c < 60; c++) begin
            tick();
            n_tests++;
            if ({Dout, word_strobe, train_active, run_len_err, obs_ready} !==
                {exp_dout, exp_ws, exp_ta, exp_err, exp_ready}) begin
                n_fail++;
                $display("FAIL runlen cyc %0d: got {dout,ws,ta,err,rdy}=%b want %b", c,
                         {Dout, word_strobe, train_active, run_len_err, obs_ready},
                         {exp_dout, exp_ws, exp_ta, exp_err, exp_ready});
            end
            if (accepted) begin
                nacc++;
                if (nacc == 2) word_bus.Din_valid = 1'b0;
            end
            if (Dout === 1'b0) zr++;
            else zr = 0;
            if (run_len_err === 1'b1 && !seen) begin
                seen = 1'b1;
                rise_zr = zr;
            end
        end
        word_bus.Din_valid = 1'b0;
        n_tests++;
        if (!found || nacc != 2 || rise_zr != 6) begin
            n_fail++;
            $display("FAIL runlen_rise: got found=%b accepts=%0d zeros at rise=%0d want 1, 2, 6", found, nacc, rise_zr);
        end
        n_tests++;
        if (run_len_err !== 1'b1) begin
            n_fail++;
            $display("FAIL runlen_sticky: got %b want 1", run_len_err);
        end
    endtask

    initial begin
        word_bus.Din = '0;
        word_bus.Din_valid = 1'b0;
        test_reset();
        test_training();
        test_single_word();
        test_back_to_back();
        test_train_req();
        test_mid_reset();
        test_run_len();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
